// File: rtl/pkt_arb_2to1_if.sv
// -----------------------------------------------------------------------------
// pkt_arb_2to1_if
// Packet/flag write bundle shared by the arbiter's two ingress ports and its
// egress port.
//
// Transfer rule (used on every instance of this bundle):
//   A packet word moves on each rising clk edge where pkt_wrreq is high, and a
//   per-packet flag moves on each rising edge where valid_wrreq is high. There
//   is no ready signal: the writer watches pkt_usedw (fill level of the
//   receiving packet FIFO) and never writes more than the receiver can hold.
//
// Signals:
//   pkt_wrreq    packet word write strobe
//   pkt[138:0]   packet word, [138:136] 101=head, 100=body, 110=tail
//   pkt_usedw    receiver packet FIFO fill level
//   valid_wrreq  per-packet flag write strobe
//   valid        flag: 1=forward, 0=drop
//
// Modports:
//   master  the writer (drives the strobes and data, reads pkt_usedw)
//   slave   the receiver (reads the strobes and data, drives pkt_usedw)
// -----------------------------------------------------------------------------
interface pkt_arb_2to1_if;
   logic         pkt_wrreq;
   logic [138:0] pkt;
   logic [7:0]   pkt_usedw;
   logic         valid_wrreq;
   logic         valid;

   modport master (
      output pkt_wrreq,
      output pkt,
      output valid_wrreq,
      output valid,
      input  pkt_usedw
   );

   modport slave (
      input  pkt_wrreq,
      input  pkt,
      input  valid_wrreq,
      input  valid,
      output pkt_usedw
   );
endinterface

// File: rtl/pkt_arb_2to1.sv
// -----------------------------------------------------------------------------
// pkt_arb_2to1
// Packet-granular round-robin arbiter sharing one downstream packet/flag FIFO
// pair between two upstream ports. Each port is buffered in its own show-ahead
// packet FIFO (256 x 139) and flag FIFO (64 x 1). A granted packet is
// forwarded word by word without bubbles; a packet whose flag is 0 is drained
// and dropped. Forwarded and dropped packets are counted per port.
//
// Ports:
//   clk        clock
//   reset      synchronous active-low reset (also flushes the internal FIFOs)
//   in0, in1   ingress bundles (slave side): words, flags, FIFO fill level
//   out        egress bundle (master side): words, flags, downstream fill level
//   fwd_cnt0/1 packets forwarded per port (wrap at 2^CNT_W)
//   drop_cnt0/1 packets dropped per port (wrap at 2^CNT_W)
//   dbg_state  current arbiter state (0=IDLE, 1=SEND, 2=DROP)
//
// Parameters:
//   THRESH     a packet starts only while out.pkt_usedw < THRESH
//   CNT_W      width of the statistics counters
// -----------------------------------------------------------------------------

// Show-ahead synchronous FIFO: q always presents the oldest entry; rdreq pops
// it on the clock edge. clr empties the FIFO on the clock edge.
module pkt_arb_2to1_fifo #(
   parameter int W  = 139,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          wrreq,
   input  logic [W-1:0]  data,
   input  logic          rdreq,
   output logic [W-1:0]  q,
   output logic [AW:0]   level
);
   localparam int          DEPTH    = 1 << AW;
   localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_wr;
   logic          do_rd;

   assign do_rd = rdreq && (level != '0);
   // A full FIFO still accepts a word when a pop frees a slot on the same edge.
   assign do_wr = wrreq && ((level != FULL_LVL) || do_rd);
   assign q     = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= data;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_wr && !do_rd) begin
            level <= level + 1'b1;
         end else if (do_rd && !do_wr) begin
            level <= level - 1'b1;
         end
      end
   end
endmodule

module pkt_arb_2to1 #(
   parameter int unsigned THRESH = 161,
   parameter int          CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   pkt_arb_2to1_if.slave     in0,
   pkt_arb_2to1_if.slave     in1,
   pkt_arb_2to1_if.master    out,
   output logic [CNT_W-1:0]  fwd_cnt0,
   output logic [CNT_W-1:0]  fwd_cnt1,
   output logic [CNT_W-1:0]  drop_cnt0,
   output logic [CNT_W-1:0]  drop_cnt1,
   output logic [1:0]        dbg_state
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DROP = 2'd2
   } state_t;

   localparam logic [2:0] HDR_TAIL = 3'b110;

   // ---------------------------------------------------------------- FIFOs
   logic         fifo_clr;
   logic [138:0] p0_q, p1_q;
   logic [8:0]   p0_level, p1_level;
   logic [0:0]   v0_q, v1_q;
   logic [6:0]   v0_level, v1_level;
   logic         p0_rd, p1_rd, v0_rd, v1_rd;

   assign fifo_clr = !reset;

   pkt_arb_2to1_fifo #(.W(139), .AW(8)) u_pkt0 (
      .clk(clk), .clr(fifo_clr), .wrreq(in0.pkt_wrreq), .data(in0.pkt),
      .rdreq(p0_rd), .q(p0_q), .level(p0_level)
   );
   pkt_arb_2to1_fifo #(.W(139), .AW(8)) u_pkt1 (
      .clk(clk), .clr(fifo_clr), .wrreq(in1.pkt_wrreq), .data(in1.pkt),
      .rdreq(p1_rd), .q(p1_q), .level(p1_level)
   );
   pkt_arb_2to1_fifo #(.W(1), .AW(6)) u_vld0 (
      .clk(clk), .clr(fifo_clr), .wrreq(in0.valid_wrreq), .data(in0.valid),
      .rdreq(v0_rd), .q(v0_q), .level(v0_level)
   );
   pkt_arb_2to1_fifo #(.W(1), .AW(6)) u_vld1 (
      .clk(clk), .clr(fifo_clr), .wrreq(in1.valid_wrreq), .data(in1.valid),
      .rdreq(v1_rd), .q(v1_q), .level(v1_level)
   );

   // A full 256-word FIFO reports 0, matching the 8-bit usedw of the vendor part.
   assign in0.pkt_usedw = p0_level[7:0];
   assign in1.pkt_usedw = p1_level[7:0];

   // ------------------------------------------------------------ registers
   state_t             state_r, state_d;
   logic               gnt_r, gnt_d;        // latched granted port id
   logic               ptr_r, ptr_d;        // round-robin priority port
   logic               pkt_rdreq_r, pkt_rdreq_d;
   logic               valid_rdreq_r, valid_rdreq_d;
   logic [138:0]       out_pkt_r, out_pkt_d;
   logic               out_pkt_wrreq_r, out_pkt_wrreq_d;
   logic               out_valid_wrreq_r, out_valid_wrreq_d;
   logic               out_valid_r, out_valid_d;
   logic [CNT_W-1:0]   fwd0_r, fwd0_d, fwd1_r, fwd1_d;
   logic [CNT_W-1:0]   drop0_r, drop0_d, drop1_r, drop1_d;

   // ------------------------------------------------------ arbitration terms
   logic         pend0, pend1;
   logic         room;
   logic         sel;
   logic         sel_valid;
   logic [138:0] cur_q;
   logic         is_tail;

   // The flag is written at or after the tail word, so a non-empty flag FIFO
   // means a complete packet is buffered. The packet-level term only guards
   // against a misbehaving upstream.
   assign pend0     = (v0_level != '0) && (p0_level != '0);
   assign pend1     = (v1_level != '0) && (p1_level != '0);
   assign room      = 32'(out.pkt_usedw) < THRESH;
   assign sel       = (pend0 && pend1) ? ptr_r : pend1;
   assign sel_valid = sel ? v1_q[0] : v0_q[0];
   assign cur_q     = gnt_r ? p1_q : p0_q;
   assign is_tail   = (cur_q[138:136] == HDR_TAIL);

   // Only the granted port's FIFOs are ever popped.
   assign p0_rd = pkt_rdreq_r   && !gnt_r;
   assign p1_rd = pkt_rdreq_r   &&  gnt_r;
   assign v0_rd = valid_rdreq_r && !gnt_r;
   assign v1_rd = valid_rdreq_r &&  gnt_r;

   // --------------------------------------------------------- next state
   always_comb begin
      state_d           = state_r;
      gnt_d             = gnt_r;
      ptr_d             = ptr_r;
      pkt_rdreq_d       = 1'b0;
      valid_rdreq_d     = 1'b0;
      out_pkt_d         = out_pkt_r;
      out_pkt_wrreq_d   = 1'b0;
      out_valid_wrreq_d = 1'b0;
      out_valid_d       = 1'b0;
      fwd0_d            = fwd0_r;
      fwd1_d            = fwd1_r;
      drop0_d           = drop0_r;
      drop1_d           = drop1_r;

      case (state_r)
         IDLE: begin
            // Headroom is checked only here; a started packet always finishes.
            if (room && (pend0 || pend1)) begin
               gnt_d         = sel;
               pkt_rdreq_d   = 1'b1;
               valid_rdreq_d = 1'b1;
               state_d       = sel_valid ? SEND : DROP;
            end
         end

         SEND: begin
            out_pkt_d       = cur_q;
            out_pkt_wrreq_d = 1'b1;
            if (is_tail) begin
               out_valid_wrreq_d = 1'b1;
               out_valid_d       = 1'b1;
               ptr_d             = !gnt_r;
               state_d           = IDLE;
               if (gnt_r) begin
                  fwd1_d = fwd1_r + 1'b1;
               end else begin
                  fwd0_d = fwd0_r + 1'b1;
               end
            end else begin
               pkt_rdreq_d = 1'b1;
            end
         end

         DROP: begin
            if (is_tail) begin
               ptr_d   = !gnt_r;
               state_d = IDLE;
               if (gnt_r) begin
                  drop1_d = drop1_r + 1'b1;
               end else begin
                  drop0_d = drop0_r + 1'b1;
               end
            end else begin
               pkt_rdreq_d = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------- state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r           <= IDLE;
         gnt_r             <= 1'b0;
         ptr_r             <= 1'b0;
         pkt_rdreq_r       <= 1'b0;
         valid_rdreq_r     <= 1'b0;
         out_pkt_r         <= '0;
         out_pkt_wrreq_r   <= 1'b0;
         out_valid_wrreq_r <= 1'b0;
         out_valid_r       <= 1'b0;
         fwd0_r            <= '0;
         fwd1_r            <= '0;
         drop0_r           <= '0;
         drop1_r           <= '0;
      end else begin
         state_r           <= state_d;
         gnt_r             <= gnt_d;
         ptr_r             <= ptr_d;
         pkt_rdreq_r       <= pkt_rdreq_d;
         valid_rdreq_r     <= valid_rdreq_d;
         out_pkt_r         <= out_pkt_d;
         out_pkt_wrreq_r   <= out_pkt_wrreq_d;
         out_valid_wrreq_r <= out_valid_wrreq_d;
         out_valid_r       <= out_valid_d;
         fwd0_r            <= fwd0_d;
         fwd1_r            <= fwd1_d;
         drop0_r           <= drop0_d;
         drop1_r           <= drop1_d;
      end
   end

   // -------------------------------------------------------------- outputs
   assign out.pkt_wrreq   = out_pkt_wrreq_r;
   assign out.pkt         = out_pkt_r;
   assign out.valid_wrreq = out_valid_wrreq_r;
   assign out.valid       = out_valid_r;
   assign fwd_cnt0        = fwd0_r;
   assign fwd_cnt1        = fwd1_r;
   assign drop_cnt0       = drop0_r;
   assign drop_cnt1       = drop1_r;
   assign dbg_state       = state_r;
endmodule

// File: tb/tb_pkt_arb_2to1.sv
// -----------------------------------------------------------------------------
// tb_pkt_arb_2to1
// Bench for pkt_arb_2to1. Expected egress words ({valid_wrreq, pkt}) are
// queued in the order the round-robin must produce them; a monitor pops and
// compares on every egress word. A second instance with 8-bit counters covers
// counter wrap without a 65536-packet run.
// -----------------------------------------------------------------------------
module tb_pkt_arb_2to1;
   // ------------------------------------------------------ clock and reset
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------ DUTs
   pkt_arb_2to1_if in0_if ();
   pkt_arb_2to1_if in1_if ();
   pkt_arb_2to1_if out_if ();
   pkt_arb_2to1_if w_in0_if ();
   pkt_arb_2to1_if w_in1_if ();
   pkt_arb_2to1_if w_out_if ();

   logic [15:0] fwd_cnt0, fwd_cnt1, drop_cnt0, drop_cnt1;
   logic [1:0]  dbg_state;
   logic [7:0]  w_fwd0, w_fwd1, w_drop0, w_drop1;
   logic [1:0]  w_dbg_state;

   pkt_arb_2to1 #(.THRESH(161), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset), .in0(in0_if), .in1(in1_if), .out(out_if),
      .fwd_cnt0(fwd_cnt0), .fwd_cnt1(fwd_cnt1),
      .drop_cnt0(drop_cnt0), .drop_cnt1(drop_cnt1), .dbg_state(dbg_state)
   );

   pkt_arb_2to1 #(.THRESH(161), .CNT_W(8)) u_wrap (
      .clk(clk), .reset(reset), .in0(w_in0_if), .in1(w_in1_if), .out(w_out_if),
      .fwd_cnt0(w_fwd0), .fwd_cnt1(w_fwd1),
      .drop_cnt0(w_drop0), .drop_cnt1(w_drop1), .dbg_state(w_dbg_state)
   );

   // ------------------------------------------------------ scoreboard state
   logic [139:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;
   bit mon_en  = 1'b1;
   int w_out_words = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [138:0] mk_word(input int tag, input int i, input int n);
      logic [2:0] h;
      h = (i == 0) ? 3'b101 : ((i == n - 1) ? 3'b110 : 3'b100);
      return {h, 120'd0, tag[7:0], i[7:0]};
   endfunction

   function automatic void exp_pkt(input int tag, input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({(i == n - 1), mk_word(tag, i, n)});
      end
   endfunction

   // ---------------------------------------------------------- drivers
   task automatic drive_word(input int port, input logic wr, input logic [138:0] d,
                             input logic vwr, input logic v);
      case (port)
         0: begin
            in0_if.pkt_wrreq = wr; in0_if.pkt = d;
            in0_if.valid_wrreq = vwr; in0_if.valid = v;
         end
         1: begin
            in1_if.pkt_wrreq = wr; in1_if.pkt = d;
            in1_if.valid_wrreq = vwr; in1_if.valid = v;
         end
         default: begin
            w_in0_if.pkt_wrreq = wr; w_in0_if.pkt = d;
            w_in0_if.valid_wrreq = vwr; w_in0_if.valid = v;
         end
      endcase
   endtask

   // Writes an n-word packet, flag written together with the tail word.
   task automatic put_pkt(input int port, input int n, input logic vld, input int tag);
      for (int i = 0; i < n; i++) begin
         drive_word(port, 1'b1, mk_word(tag, i, n), (i == n - 1), vld);
         @(negedge clk);
      end
      drive_word(port, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int stable;
      int cyc;
      stable = 0;
      cyc = 0;
      while (stable < 3 && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (exp_q.size() == 0 && dbg_state == 2'd0 && in0_if.pkt_usedw == 8'd0 &&
             in1_if.pkt_usedw == 8'd0 && !out_if.pkt_wrreq) stable++;
         else stable = 0;
      end
      n_tests++;
      if (stable < 3) begin
         n_fail++;
         $display("FAIL %s_timeout: got %0d words still expected, required 0", name, exp_q.size());
      end
   endtask

   // ---------------------------------------------------------- monitors
   always @(negedge clk) begin
      if (mon_en && reset) begin
         if (out_if.pkt_wrreq === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_word: got %h with nothing expected", out_if.pkt);
            end else begin
               logic [139:0] e;
               e = exp_q.pop_front();
               if ({out_if.valid_wrreq, out_if.pkt} !== e || (out_if.valid_wrreq && out_if.valid !== 1'b1)) begin
                  n_fail++;
                  $display("FAIL out_word: got vwr=%b v=%b pkt=%h expected vwr=%b v=1 pkt=%h",
                           out_if.valid_wrreq, out_if.valid, out_if.pkt, e[139], e[138:0]);
               end
            end
         end else if (out_if.valid_wrreq === 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL stray_valid_wrreq: got 1 without a word, expected 0");
         end
      end
   end

   always @(negedge clk) begin
      if (reset && w_out_if.pkt_wrreq === 1'b1) w_out_words++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------- stimulus
   initial begin
      int lat;
      int run;
      bit found;

      drive_word(0, 1'b0, '0, 1'b0, 1'b0);
      drive_word(1, 1'b0, '0, 1'b0, 1'b0);
      drive_word(2, 1'b0, '0, 1'b0, 1'b0);
      w_in1_if.pkt_wrreq = 1'b0; w_in1_if.pkt = '0;
      w_in1_if.valid_wrreq = 1'b0; w_in1_if.valid = 1'b0;
      out_if.pkt_usedw = 8'd0;
      w_out_if.pkt_usedw = 8'd0;

      // Reset values
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out_pkt_wrreq", 32'(out_if.pkt_wrreq), 0);
      check("rst_out_valid_wrreq", 32'(out_if.valid_wrreq), 0);
      check("rst_out_valid", 32'(out_if.valid), 0);
      check("rst_out_pkt_nonzero", 32'(out_if.pkt != '0), 0);
      check("rst_state", 32'(dbg_state), 0);
      check("rst_counters", 32'(fwd_cnt0 | fwd_cnt1 | drop_cnt0 | drop_cnt1), 0);
      check("rst_in0_usedw", 32'(in0_if.pkt_usedw), 0);
      reset = 1'b1;
      @(negedge clk);

      // T1: single 4-word packet on port 0, words back to back
      exp_pkt(8'h10, 4);
      put_pkt(0, 4, 1'b1, 8'h10);
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (out_if.pkt_wrreq) found = 1'b1;
      end
      run = found ? 1 : 0;
      for (int c = 0; c < 20 && found; c++) begin
         @(negedge clk);
         if (out_if.pkt_wrreq) run++;
         else found = 1'b0;
      end
      check("t1_consecutive_words", 32'(run), 4);
      wait_idle("t1", 50);
      check("t1_fwd_cnt0", 32'(fwd_cnt0), 1);
      check("t1_drop_cnt0", 32'(drop_cnt0), 0);

      // T2: both ports, three 2-word packets each, alternating output
      do_reset();
      for (int k = 0; k < 3; k++) begin
         exp_pkt(8'h20 + k, 2);
         exp_pkt(8'h30 + k, 2);
      end
      fork
         begin
            for (int k = 0; k < 3; k++) put_pkt(0, 2, 1'b1, 8'h20 + k);
         end
         begin
            for (int k = 0; k < 3; k++) put_pkt(1, 2, 1'b1, 8'h30 + k);
         end
      join
      wait_idle("t2", 100);
      check("t2_fwd_cnt0", 32'(fwd_cnt0), 3);
      check("t2_fwd_cnt1", 32'(fwd_cnt1), 3);

      // T3: dropped 3-word packet then valid 2-word packet on port 1
      do_reset();
      exp_pkt(8'h51, 2);
      put_pkt(1, 3, 1'b0, 8'h50);
      put_pkt(1, 2, 1'b1, 8'h51);
      wait_idle("t3", 60);
      check("t3_drop_cnt1", 32'(drop_cnt1), 1);
      check("t3_fwd_cnt1", 32'(fwd_cnt1), 1);
      check("t3_fwd_cnt0", 32'(fwd_cnt0), 0);

      // T4: downstream threshold gating
      do_reset();
      out_if.pkt_usedw = 8'd161;
      put_pkt(0, 4, 1'b1, 8'h40);
      run = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_if.pkt_wrreq) run++;
      end
      check("t4_blocked_words", 32'(run), 0);
      check("t4_blocked_state", 32'(dbg_state), 0);
      check("t4_in0_usedw", 32'(in0_if.pkt_usedw), 4);
      exp_pkt(8'h40, 4);
      out_if.pkt_usedw = 8'd160;
      lat = 0;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         lat++;
         if (out_if.pkt_wrreq) found = 1'b1;
      end
      check("t4_start_latency", 32'(lat), 2);
      out_if.pkt_usedw = 8'd200;
      wait_idle("t4", 50);
      check("t4_fwd_cnt0", 32'(fwd_cnt0), 1);
      out_if.pkt_usedw = 8'd0;

      // T5: reset in the middle of a 10-word packet
      mon_en = 1'b0;
      put_pkt(0, 10, 1'b1, 8'h60);
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (out_if.pkt_wrreq) found = 1'b1;
      end
      check("t5_started", 32'(found), 1);
      repeat (2) @(negedge clk);
      check("t5_mid_send_state", 32'(dbg_state), 1);
      check("t5_in0_usedw_before", 32'(in0_if.pkt_usedw), 7);
      check("t5_fwd_cnt0_before", 32'(fwd_cnt0), 1);
      reset = 1'b0;
      @(negedge clk);
      check("t5_out_pkt_wrreq", 32'(out_if.pkt_wrreq), 0);
      check("t5_out_valid_wrreq", 32'(out_if.valid_wrreq), 0);
      check("t5_out_pkt_nonzero", 32'(out_if.pkt != '0), 0);
      check("t5_fwd_cnt0", 32'(fwd_cnt0), 0);
      check("t5_in0_usedw", 32'(in0_if.pkt_usedw), 0);
      check("t5_state", 32'(dbg_state), 0);
      reset = 1'b1;
      exp_q.delete();
      repeat (2) @(negedge clk);
      mon_en = 1'b1;

      // T6: drop counter wrap on the 8-bit-counter instance
      for (int k = 0; k < 255; k++) begin
         put_pkt(2, 2, 1'b0, k);
         @(negedge clk);
      end
      repeat (20) @(negedge clk);
      check("t6_drop_255", 32'(w_drop0), 255);
      put_pkt(2, 2, 1'b0, 255);
      repeat (10) @(negedge clk);
      check("t6_drop_wrap", 32'(w_drop0), 0);
      put_pkt(2, 2, 1'b0, 1);
      repeat (10) @(negedge clk);
      check("t6_drop_after_wrap", 32'(w_drop0), 1);
      check("t6_fwd_cnt0", 32'(w_fwd0), 0);
      check("t6_no_output", 32'(w_out_words), 0);
      check("t6_state", 32'(w_dbg_state), 0);
      check("t6_in0_usedw", 32'(w_in0_if.pkt_usedw), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
